// File: rtl/fifo_ser_pkg.sv
// Shared definitions for the wide-FIFO word serializer and its matching deserializer.
package fifo_ser_pkg;

    localparam int unsigned IN_WIDTH_DEF  = 704;
    localparam int unsigned OUT_WIDTH_DEF = 32;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } ser_state_e;

    // Words carried by one wide element.
    function automatic int unsigned beats_f(input int unsigned in_w, input int unsigned out_w);
        return in_w / out_w;
    endfunction

    // Beat counter width; at least one bit even for a single-beat element.
    function automatic int unsigned cnt_w_f(input int unsigned beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/fifo_word_serializer.sv
// Pulls one wide element from the upstream FIFO and emits it as OUT_WIDTH words,
// least-significant word first, through an enq-style method interface.
module fifo_word_serializer
    import fifo_ser_pkg::*;
#(
    parameter int unsigned IN_WIDTH  = IN_WIDTH_DEF,
    parameter int unsigned OUT_WIDTH = OUT_WIDTH_DEF
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [IN_WIDTH-1:0]  in_first,
    input  logic                 in_first_rdy,
    input  logic                 in_deq_rdy,
    output logic                 in_deq_ena,
    input  logic                 out_enq_rdy,
    output logic                 out_enq_ena,
    output logic [OUT_WIDTH-1:0] out_enq_v,
    output logic                 out_last,
    output logic                 busy
);

    localparam int unsigned BEATS = beats_f(IN_WIDTH, OUT_WIDTH);
    localparam int unsigned CNT_W = cnt_w_f(BEATS);

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    localparam logic [0:0] S_IDLE = 1'(IDLE);
    localparam logic [0:0] S_SEND = 1'(SEND);

    if ((IN_WIDTH % OUT_WIDTH) != 0 || IN_WIDTH < OUT_WIDTH) begin : g_bad_width
        $error("fifo_word_serializer: IN_WIDTH must be a whole multiple of OUT_WIDTH");
    end

    logic [0:0]          state;
    logic [0:0]          state_nxt;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    cnt_nxt;
    logic [IN_WIDTH-1:0] sreg;
    logic [IN_WIDTH-1:0] sreg_nxt;

    logic enq_ena;
    logic deq_ena;
    logic last_beat;
    logic load;

    // State, counter and shift register; RST wins over everything.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= S_IDLE;
            cnt   <= '0;
            sreg  <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            sreg  <= sreg_nxt;
        end
    end

    // Handshakes and next state; a reset cycle performs no method calls.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        sreg_nxt  = sreg;

        last_beat = (cnt == LAST_BEAT);
        enq_ena   = !RST && (state == S_SEND) && out_enq_rdy;
        load      = (state == S_IDLE) || (enq_ena && last_beat);
        deq_ena   = !RST && load && in_deq_rdy && in_first_rdy;

        if (deq_ena) begin
            sreg_nxt  = in_first;
            cnt_nxt   = '0;
            state_nxt = S_SEND;
        end else if (enq_ena) begin
            if (last_beat) begin
                sreg_nxt  = '0;
                cnt_nxt   = '0;
                state_nxt = S_IDLE;
            end else begin
                sreg_nxt = sreg >> OUT_WIDTH;
                cnt_nxt  = cnt + CNT_W'(1);
            end
        end
    end

    assign in_deq_ena  = deq_ena;
    assign out_enq_ena = enq_ena;
    assign busy        = (state == S_SEND);
    assign out_last    = (state == S_SEND) && last_beat;
    assign out_enq_v   = (state == S_SEND) ? sreg[OUT_WIDTH-1:0] : '0;

endmodule

// File: tb/tb_fifo_word_serializer.sv
// Self-checking bench: upstream FIFO model plus a word-order scoreboard for fifo_word_serializer.
module tb_fifo_word_serializer;
    import fifo_ser_pkg::*;

    localparam int unsigned IW = 704;
    localparam int unsigned OW = 32;
    localparam int unsigned NB = IW / OW;

    logic          CLK;
    logic          RST;
    logic [IW-1:0] in_first;
    logic          first_rdy;
    logic          deq_rdy;
    logic          deq_ena;
    logic          enq_rdy;
    logic          enq_ena;
    logic [OW-1:0] out_v;
    logic          out_last;
    logic          busy;

    // Upstream FIFO: circular element store, popped on each deq call.
    logic [IW-1:0] elem_mem [0:127];
    logic [6:0]    rd_ptr = '0;
    logic [6:0]    wr_ptr = '0;
    logic          up_en;

    assign in_first  = elem_mem[rd_ptr];
    assign first_rdy = up_en && (wr_ptr != rd_ptr);

    always @(posedge CLK) if (deq_ena) rd_ptr <= rd_ptr + 7'd1;

    fifo_word_serializer dut (
        .CLK          (CLK),
        .RST          (RST),
        .in_first     (in_first),
        .in_first_rdy (first_rdy),
        .in_deq_rdy   (deq_rdy),
        .in_deq_ena   (deq_ena),
        .out_enq_rdy  (enq_rdy),
        .out_enq_ena  (enq_ena),
        .out_enq_v    (out_v),
        .out_last     (out_last),
        .busy         (busy)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int n_checks = 0;
    int n_fail   = 0;
    int n_words, n_deq, n_last, n_deq_on_last, run_len, max_run;
    logic [31:0] last_word;
    logic [31:0] got_q [$];
    logic [31:0] exp_q [$];
    bit          chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_stats();
        n_words = 0; n_deq = 0; n_last = 0; n_deq_on_last = 0;
        run_len = 0; max_run = 0; last_word = '0;
        got_q.delete();
    endtask

    function automatic logic [IW-1:0] mk(input logic [31:0] base, input bit rnd);
        logic [IW-1:0] e;
        for (int k = 0; k < NB; k++) e[k*OW +: OW] = rnd ? 32'($urandom) : base + 32'(k);
        return e;
    endfunction

    task automatic push(input logic [IW-1:0] e);
        elem_mem[wr_ptr] = e;
        wr_ptr = wr_ptr + 7'd1;
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_words(input int n, input int bound);
        for (int i = 0; i < bound; i++) begin
            if (n_words == n) return;
            step();
        end
        chk("wait_words_timeout", 32'(n_words), 32'(n));
    endtask

    // Model: words still owed to the consumer, in order; drives every per-cycle check.
    always @(negedge CLK) begin : cmp
        int sz;
        bit e_busy, e_enq, e_deq;
        if (chk_en) begin
            sz     = exp_q.size();
            e_busy = (sz > 0);
            e_enq  = !RST && e_busy && enq_rdy;
            e_deq  = !RST && first_rdy && deq_rdy && (sz == 0 || (sz == 1 && enq_rdy));
            chk("busy", 32'(busy), 32'(e_busy));
            chk("enq_ena", 32'(enq_ena), 32'(e_enq));
            chk("deq_ena", 32'(deq_ena), 32'(e_deq));
            chk("last", 32'(out_last), 32'(e_busy && sz == 1));
            if (e_busy) chk("enq_v", out_v, exp_q[0]);
            if (RST) begin
                exp_q.delete();
                run_len = 0;
            end else begin
                if (enq_ena) begin
                    n_words++;
                    got_q.push_back(out_v);
                    if (out_last) begin n_last++; last_word = out_v; end
                    run_len++;
                end else begin
                    run_len = 0;
                end
                if (run_len > max_run) max_run = run_len;
                if (e_enq) exp_q.delete(0);
                if (deq_ena) begin
                    n_deq++;
                    if (out_last && enq_ena) n_deq_on_last++;
                end
                if (e_deq)
                    for (int k = 0; k < NB; k++) exp_q.push_back(elem_mem[rd_ptr][k*OW +: OW]);
            end
        end
    end

    initial begin
        RST = 1'b1; up_en = 1'b0; deq_rdy = 1'b0; enq_rdy = 1'b0;
        clear_stats();
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_enq_ena", 32'(enq_ena), 32'd0);
        chk("rst_deq_ena", 32'(deq_ena), 32'd0);
        chk("rst_last", 32'(out_last), 32'd0);
        chk("rst_enq_v", out_v, 32'd0);
        chk_en = 1'b1;
        step();
        RST = 1'b0;

        // Upstream empty, then head present but deq not ready.
        deq_rdy = 1'b1; enq_rdy = 1'b1;
        repeat (10) step();
        chk("empty_deq", 32'(n_deq), 32'd0);
        chk("empty_words", 32'(n_words), 32'd0);
        chk("empty_busy", 32'(busy), 32'd0);
        push(mk(32'h1000_0000, 1'b0));
        up_en = 1'b1; deq_rdy = 1'b0;
        repeat (5) step();
        chk("nodeq_capture", 32'(n_deq), 32'd0);
        chk("nodeq_busy", 32'(busy), 32'd0);

        // Single element.
        deq_rdy = 1'b1;
        repeat (30) step();
        chk("single_deq", 32'(n_deq), 32'd1);
        chk("single_words", 32'(n_words), 32'd22);
        chk("single_w0", got_q[0], 32'h1000_0000);
        chk("single_w21", got_q[21], 32'h1000_0015);
        chk("single_nlast", 32'(n_last), 32'd1);
        chk("single_lastw", last_word, 32'h1000_0015);
        chk("single_run", 32'(max_run), 32'd22);
        chk("single_idle", 32'(busy), 32'd0);

        // Back-to-back elements.
        clear_stats();
        push(mk(32'hA000_0000, 1'b0));
        push(mk(32'hB000_0000, 1'b0));
        repeat (60) step();
        chk("b2b_words", 32'(n_words), 32'd44);
        chk("b2b_run", 32'(max_run), 32'd44);
        chk("b2b_deq", 32'(n_deq), 32'd2);
        chk("b2b_deq_on_last", 32'(n_deq_on_last), 32'd1);
        chk("b2b_w21", got_q[21], 32'hA000_0015);
        chk("b2b_w22", got_q[22], 32'hB000_0000);
        chk("b2b_w43", got_q[43], 32'hB000_0015);

        // Downstream stall at beat 7.
        clear_stats();
        push(mk(32'hC000_0000, 1'b0));
        wait_words(7, 100);
        enq_rdy = 1'b0;
        repeat (5) begin
            @(negedge CLK);
            chk("stall_v", out_v, 32'hC000_0007);
            chk("stall_ena", 32'(enq_ena), 32'd0);
            step();
        end
        enq_rdy = 1'b1;
        repeat (30) step();
        chk("stall_words", 32'(n_words), 32'd22);
        chk("stall_w7", got_q[7], 32'hC000_0007);
        chk("stall_w8", got_q[8], 32'hC000_0008);
        chk("stall_w21", got_q[21], 32'hC000_0015);

        // Reset in the middle of an element.
        clear_stats();
        push(mk(32'hD000_0000, 1'b0));
        wait_words(10, 100);
        RST = 1'b1; up_en = 1'b0;
        step();
        RST = 1'b0;
        @(negedge CLK);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_enq", 32'(enq_ena), 32'd0);
        chk("mid_rst_deq", 32'(deq_ena), 32'd0);
        chk("mid_rst_last", 32'(out_last), 32'd0);
        chk("mid_rst_v", out_v, 32'd0);
        step();
        clear_stats();
        push(mk(32'hE000_0000, 1'b0));
        up_en = 1'b1;
        repeat (30) step();
        chk("post_rst_words", 32'(n_words), 32'd22);
        chk("post_rst_w0", got_q[0], 32'hE000_0000);
        chk("post_rst_w21", got_q[21], 32'hE000_0015);
        chk("post_rst_nlast", 32'(n_last), 32'd1);

        // Randomised ready on both sides, 50 elements.
        clear_stats();
        for (int i = 0; i < 50; i++) push(mk(32'h0, 1'b1));
        for (int c = 0; c < 20000; c++) begin
            if (rd_ptr == wr_ptr && !busy && exp_q.size() == 0) break;
            up_en   = ($urandom_range(0, 3) != 0);
            deq_rdy = ($urandom_range(0, 3) != 0);
            enq_rdy = ($urandom_range(0, 3) != 0);
            step();
        end
        up_en = 1'b1; deq_rdy = 1'b1; enq_rdy = 1'b1;
        step();
        chk("rand_words", 32'(n_words), 32'd1100);
        chk("rand_deq", 32'(n_deq), 32'd50);
        chk("rand_nlast", 32'(n_last), 32'd50);
        chk("rand_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
